led_breath_ctrl: RTL and testbench
==================================

Name: led_breath_ctrl

Overview:
- Upstream duty-cycle generator for the 8-bit PWM LED driver. It produces the 8-bit brightness word the driver consumes.
- Breath mode: a prescaled state machine ramps duty 0→255, holds, ramps 255→0, holds, and repeats.
- Manual mode: a user-supplied level passes through to the driver.
- Registered output; stable between ticks so the PWM period never sees glitches.

Parameters:
- CLK_DIV, 390625, clk cycles per ramp tick (100 MHz → 3.9 ms; ~2 s ramp up plus ramp down); minimum 2.
- STEP, 1, duty increment/decrement per tick; range 1..128.
- HOLD_TICKS, 64, ticks spent in each hold state; minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low forces output dark.
- manual  in  1  1 = manual mode, 0 = breath mode.
- manual_level  in  8  duty used in manual mode.
- duty_out  out  8  brightness word to the PWM driver's 8-bit duty input.
- breath_done  out  1  one-cycle pulse at the end of each full breath cycle.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately on rst_n low.
- Reset values: duty_out=0, breath_done=0, state=S_OFF, prescaler=0, hold counter=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 for the single cycle in which the count equals CLK_DIV-1.
  - Runs only in the ramp/hold states; held at 0 in S_OFF and S_MANUAL.
- States: S_OFF, S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO, S_MANUAL.
- Priority of transitions, evaluated every cycle: en low > manual > tick-driven ramp logic.
  - en=0 from any state → S_OFF next cycle; duty_out=0; prescaler and hold counter cleared.
  - S_OFF, en=1: manual=1 → S_MANUAL; else → S_UP with duty 0.
  - en=1, manual=1 from any breath state → S_MANUAL.
  - S_MANUAL: duty_out <= manual_level every cycle (1-cycle latency).
  - Leaving S_MANUAL (manual falls): → S_UP, ramping from the current duty_out. No jump.
- S_UP, on tick:
  - If duty_out > 255-STEP: duty_out <= 255, go S_HOLD_HI, hold counter cleared.
  - Else duty_out <= duty_out+STEP.
- S_HOLD_HI, on tick: hold counter increments. On the tick where the count reaches HOLD_TICKS-1 → S_DOWN.
- S_DOWN, on tick:
  - If duty_out < STEP: duty_out <= 0, go S_HOLD_LO.
  - Else duty_out <= duty_out-STEP.
- S_HOLD_LO, on tick: same hold counting as S_HOLD_HI. On exit → S_UP and breath_done=1 for exactly that cycle.
- Arithmetic: ramp math in 9 bits, saturating to 0..255. duty_out never wraps.
- Output latency: duty_out updates the cycle after the tick (or after the manual_level sample). No other changes occur between ticks.
- Simultaneous events:
  - en fall coincident with tick: en wins, no breath_done.
  - manual rise coincident with tick: manual wins.
- Reset mid-ramp: restart from S_OFF. After release, with en=1 the first tick arrives CLK_DIV cycles after entering S_UP.

Optional Feature:
- Macro LED_BREATH_GAMMA_EN.
- Defined: a perceptual gamma stage maps the linear duty L to duty_out = (L*L)>>8, plus 1 when L=255, so 255 maps to 255. The stage adds one registered cycle of latency in all modes. breath_done is delayed to stay aligned with the duty_out update. en=0 still yields 0 one cycle later.
- Undefined: duty_out is the linear duty directly; no extra stage.

Decomposition:
- Shared package led_pkg:
  - state enum (S_OFF..S_MANUAL, 3 bits).
  - DUTY_W=8.
  - DUTY_MAX=8'd255.
  - gamma function shared with other LED stages.
- Sub-module led_gamma: one-stage registered squarer with async active-low reset. Instantiated only under LED_BREATH_GAMMA_EN.

Test Plan (CLK_DIV=4, STEP=16, HOLD_TICKS=2 unless noted):
- Reset then en=1, manual=0:
  - duty_out steps 16, 32, … every 4 cycles; 240 then saturates at 255 (no wrap).
  - Holds for 2 ticks, then steps down 239 … 15 → 0.
  - Holds 2 ticks; breath_done pulses once, 1 cycle wide.
- STEP=100:
  - Up ramp 0, 100, 200, 255.
  - Down ramp 255, 155, 55, 0.
  - Saturation at both ends.
- Manual mode: manual=1, manual_level=8'h5A → duty_out=8'h5A one cycle later. Change manual_level to 8'hC3 → follows next cycle. Release manual → ramp resumes upward from 8'hC3.
- Mid-ramp disruptions:
  - Drop en during S_DOWN at duty 128 → duty_out=0 next cycle, no breath_done. Re-enable → ramp from 0.
  - Assert rst_n low asynchronously (between clock edges) → duty_out=0 immediately.
- Coincident events: en falling on the exact tick cycle ending S_HOLD_LO → S_OFF, breath_done stays 0.
- Gamma (LED_BREATH_GAMMA_EN, manual mode):
  - manual_level 128 → duty_out 64 two cycles later.
  - 255 → 255.
  - 0 → 0.
  - 16 → 1.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED brightness pipeline: duty word width and
// ceiling, the breath controller state encoding, and the perceptual gamma
// mapping used by every stage that needs to linearise brightness.
// No ports (package).
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4,
    S_MANUAL  = 3'd5
  } state_e;

  // Square law brightness curve: (L*L)>>8. Full scale alone would land on
  // 254, so it is pinned to DUTY_MAX to keep "fully on" really fully on.
  function automatic logic [DUTY_W-1:0] gamma8(input logic [DUTY_W-1:0] lin);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, lin} * {{DUTY_W{1'b0}}, lin};
    return (lin == DUTY_MAX) ? DUTY_MAX : sq[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/led_gamma.sv
// ---------------------------------------------------------------------------
// led_gamma
// One-stage registered gamma squarer: duty_o follows gamma8(lin_i) one clock
// later. Only exists in builds with LED_BREATH_GAMMA_EN defined, where it is
// instantiated by led_breath_ctrl.
// Ports:
//   clk_i   in   system clock
//   rst_ni  in   asynchronous active-low reset (clears output to dark)
//   lin_i   in   8-bit linear duty
//   duty_o  out  8-bit gamma-corrected duty
// ---------------------------------------------------------------------------
`ifdef LED_BREATH_GAMMA_EN
module led_gamma
  import led_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DUTY_W-1:0] lin_i,
  output logic [DUTY_W-1:0] duty_o
);

  logic [DUTY_W-1:0] gamma_q;

  // Register the mapped value so the PWM driver only ever sees a clean word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gamma_q <= '0;
    end else begin
      gamma_q <= gamma8(lin_i);
    end
  end

  assign duty_o = gamma_q;

endmodule
`endif

// File: rtl/led_breath_ctrl.sv
// ---------------------------------------------------------------------------
// led_breath_ctrl
// Duty-cycle generator feeding the 8-bit PWM LED driver. In breath mode a
// prescaled state machine ramps the duty up, holds, ramps down, holds and
// repeats; in manual mode a user level is passed through. The duty word is
// registered and only changes the cycle after a ramp tick or a manual sample.
// Optional macro LED_BREATH_GAMMA_EN adds a registered gamma stage (one extra
// cycle on duty_out and breath_done).
// Parameters:
//   CLK_DIV     clk cycles per ramp tick (>= 2)
//   STEP        duty change per tick (1..128)
//   HOLD_TICKS  ticks spent in each hold state (>= 1)
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   en            in   block enable, low forces the output dark
//   manual        in   1 = manual level, 0 = breathing
//   manual_level  in   8-bit duty used in manual mode
//   duty_out      out  8-bit duty word to the PWM driver
//   breath_done   out  one-cycle pulse at the end of each full breath
// ---------------------------------------------------------------------------
module led_breath_ctrl
  import led_pkg::*;
#(
  parameter int CLK_DIV    = 390625,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              manual,
  input  logic [DUTY_W-1:0] manual_level,
  output logic [DUTY_W-1:0] duty_out,
  output logic              breath_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_TICKS - 1);
  localparam logic [DUTY_W-1:0] STEP8      = DUTY_W'(STEP);

  state_e            state_q, state_d;
  logic [PW-1:0]     prescCnt_q, prescCnt_d;
  logic [HW-1:0]     holdCnt_q, holdCnt_d;
  logic [DUTY_W-1:0] linDuty_q, linDuty_d;
  logic              done_q, done_d;

  logic              breathing;
  logic              tick;
  logic              holdExpire;
  logic [DUTY_W:0]   upSum;
  logic              downUnder;
  logic [DUTY_W-1:0] downDiff;

  // The prescaler only runs while breathing, so tick can only fire there.
  assign breathing  = (state_q == S_UP) || (state_q == S_HOLD_HI) ||
                      (state_q == S_DOWN) || (state_q == S_HOLD_LO);
  assign tick       = breathing && (prescCnt_q == PRESC_LAST);
  assign holdExpire = tick && (holdCnt_q == HOLD_LAST);

  // Ramp math one bit wider than the duty: the carry out of upSum means the
  // next step would pass full scale, which is where the ramp saturates.
  assign upSum     = {1'b0, linDuty_q} + {1'b0, STEP8};
  assign downUnder = linDuty_q < STEP8;
  assign downDiff  = linDuty_q - STEP8;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enable dominates, then manual, then tick-driven breathing.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_OFF;
    end else if (manual) begin
      state_d = S_MANUAL;
    end else begin
      case (state_q)
        S_OFF:     state_d = S_UP;
        S_MANUAL:  state_d = S_UP;
        S_UP:      if (tick && upSum[DUTY_W]) state_d = S_HOLD_HI;
        S_HOLD_HI: if (holdExpire) state_d = S_DOWN;
        S_DOWN:    if (tick && downUnder) state_d = S_HOLD_LO;
        S_HOLD_LO: if (holdExpire) state_d = S_UP;
        default:   state_d = S_OFF;
      endcase
    end
  end

  // Datapath next values. Leaving manual keeps the sampled level so the ramp
  // continues from wherever the user left the brightness.
  always_comb begin
    prescCnt_d = '0;
    holdCnt_d  = holdCnt_q;
    linDuty_d  = linDuty_q;
    done_d     = 1'b0;
    if (!en) begin
      holdCnt_d = '0;
      linDuty_d = '0;
    end else if (manual) begin
      holdCnt_d = '0;
      linDuty_d = manual_level;
    end else begin
      if (breathing) begin
        prescCnt_d = tick ? '0 : prescCnt_q + 1'b1;
      end
      case (state_q)
        S_OFF: begin
          holdCnt_d = '0;
          linDuty_d = '0;
        end
        S_UP: begin
          if (tick) begin
            if (upSum[DUTY_W]) begin
              linDuty_d = DUTY_MAX;
              holdCnt_d = '0;
            end else begin
              linDuty_d = upSum[DUTY_W-1:0];
            end
          end
        end
        S_HOLD_HI, S_HOLD_LO: begin
          if (tick) begin
            holdCnt_d = holdExpire ? '0 : holdCnt_q + 1'b1;
            done_d    = holdExpire && (state_q == S_HOLD_LO);
          end
        end
        S_DOWN: begin
          if (tick) begin
            if (downUnder) begin
              linDuty_d = '0;
              holdCnt_d = '0;
            end else begin
              linDuty_d = downDiff;
            end
          end
        end
        default: holdCnt_d = '0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescCnt_q <= '0;
      holdCnt_q  <= '0;
      linDuty_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      prescCnt_q <= prescCnt_d;
      holdCnt_q  <= holdCnt_d;
      linDuty_q  <= linDuty_d;
      done_q     <= done_d;
    end
  end

`ifdef LED_BREATH_GAMMA_EN
  logic doneDly_q;

  led_gamma u_gamma (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .lin_i  (linDuty_q),
    .duty_o (duty_out)
  );

  // Delay the done pulse so it lines up with the gamma-stage duty update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneDly_q <= 1'b0;
    end else begin
      doneDly_q <= done_q;
    end
  end

  assign breath_done = doneDly_q;
`else
  assign duty_out    = linDuty_q;
  assign breath_done = done_q;
`endif

endmodule

// File: tb/tb_led_breath_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_breath_ctrl
// Self-checking bench for led_breath_ctrl. Instance A (CLK_DIV=4, STEP=16,
// HOLD_TICKS=2) covers breathing, manual mode, enable drop, async reset and
// the enable/tick coincidence; instance B (STEP=100) covers saturation with a
// large step. Also builds with LED_BREATH_GAMMA_EN, where expected duties are
// gamma-mapped and latency grows by one cycle.
// ---------------------------------------------------------------------------
module tb_led_breath_ctrl;

`ifdef LED_BREATH_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       enA, manualA, doneA;
  logic [7:0] levelA, dutyA;
  logic       enB, manualB, doneB;
  logic [7:0] levelB, dutyB;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] expDuty[$];
  logic [7:0] expB[$];
  logic [7:0] lastPushed  = 8'd0;
  logic [7:0] lastDuty    = 8'd0;
  logic [7:0] lastB       = 8'd0;
  int         doneCount   = 0;
  int         doneWide    = 0;
  int         doneBefore  = 0;
  logic       prevDone    = 1'b0;
  bit         monitorOn   = 1'b0;
  logic [7:0] bSeq [0:5];
  logic [7:0] boundLevels [0:3];

  led_breath_ctrl #(.CLK_DIV(4), .STEP(16), .HOLD_TICKS(2)) dutA (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (enA),
    .manual       (manualA),
    .manual_level (levelA),
    .duty_out     (dutyA),
    .breath_done  (doneA)
  );

  led_breath_ctrl #(.CLK_DIV(4), .STEP(100), .HOLD_TICKS(2)) dutB (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (enB),
    .manual       (manualB),
    .manual_level (levelB),
    .duty_out     (dutyB),
    .breath_done  (doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected PWM word for a linear duty in this build.
  function automatic logic [7:0] mapDuty(input logic [7:0] lin);
`ifdef LED_BREATH_GAMMA_EN
    logic [15:0] sq;
    sq = {8'd0, lin} * {8'd0, lin};
    return (lin == 8'hFF) ? 8'hFF : sq[15:8];
`else
    return lin;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic [7:0] lvl);
    enA     = e;
    manualA = m;
    levelA  = lvl;
  endtask

  // Queue the next expected output word; repeats collapse because the
  // monitor only sees changes.
  task automatic pushExp(input logic [7:0] lin);
    logic [7:0] v;
    v = mapDuty(lin);
    if (v !== lastPushed) begin
      expDuty.push_back(v);
      lastPushed = v;
    end
  endtask

  task automatic waitDuty(input string tag, input logic [7:0] value, input int budget);
    int n;
    n = 0;
    while (dutyA !== value && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, dutyA, value);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (doneA !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, doneA, 1'b1);
  endtask

  // Called on the negedge where breathing (re)starts from dark.
  task automatic checkFirstTick(input string tag);
    repeat (3 + LAT) @(negedge clk);
    checkOutput({tag, "Pre"}, dutyA, mapDuty(8'd0));
    @(negedge clk);
    checkOutput({tag, "Step"}, dutyA, mapDuty(8'd16));
  endtask

  // Scoreboard for instance A: every change of duty pops one expectation;
  // also tallies done pulses and any pulse longer than one cycle.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (dutyA !== lastDuty) begin
        if (expDuty.size() == 0) begin
          checkOutput("unexpectedDutyA", dutyA, lastDuty);
        end else begin
          checkOutput("dutySeqA", dutyA, expDuty.pop_front());
        end
        lastDuty = dutyA;
      end
      if (doneA === 1'b1) begin
        doneCount++;
        if (prevDone) doneWide++;
      end
      prevDone = doneA;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bSeq        = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0};
    boundLevels = '{8'd128, 8'd255, 8'd0, 8'd16};
    rst_n   = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    enB     = 1'b0;
    manualB = 1'b0;
    levelB  = 8'h00;
    #1 monitorOn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetDutyA", dutyA, 8'd0);
    checkOutput("resetDoneA", doneA, 1'b0);
    checkOutput("resetDutyB", dutyB, 8'd0);

    // Full breath: up in 16s, saturate, hold, down, hold, done.
    $display("[TB] full breath cycle");
    for (int k = 1; k <= 15; k++) pushExp(8'(16 * k));
    pushExp(8'd255);
    for (int k = 1; k <= 15; k++) pushExp(8'(255 - 16 * k));
    pushExp(8'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkFirstTick("firstTick");
    repeat (3) @(negedge clk);
    checkOutput("stableBetweenTicks", dutyA, mapDuty(8'd16));
    @(negedge clk);
    checkOutput("secondStep", dutyA, mapDuty(8'd32));
    waitDone("doneSeen1", 400);
    @(negedge clk);
    checkOutput("doneCount1", doneCount, 1);
    checkOutput("doneWidth1", doneA, 1'b0);
    checkOutput("queueDrain1", expDuty.size(), 0);

    // Manual pass-through, then resume ramping from the manual level.
    $display("[TB] manual mode");
    pushExp(8'h5A);
    applyStimulus(1'b1, 1'b1, 8'h5A);
    repeat (LAT + 1) @(negedge clk);
    checkOutput("manual5A", dutyA, mapDuty(8'h5A));
    pushExp(8'hC3);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    repeat (LAT) @(negedge clk);
    checkOutput("manualC3", dutyA, mapDuty(8'hC3));
    pushExp(8'hD3);
    pushExp(8'hE3);
    pushExp(8'hF3);
    pushExp(8'hFF);
    for (int k = 1; k <= 7; k++) pushExp(8'(255 - 16 * k));
    applyStimulus(1'b1, 1'b0, 8'hC3);
    repeat (3 + LAT) @(negedge clk);
    checkOutput("noJump", dutyA, mapDuty(8'hC3));
    @(negedge clk);
    checkOutput("resumeUp", dutyA, mapDuty(8'hD3));
    waitDuty("reach143", mapDuty(8'd143), 200);

    // Enable drop mid down-ramp.
    $display("[TB] enable drop during ramp down");
    pushExp(8'd0);
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (LAT) @(negedge clk);
    checkOutput("enDropDark", dutyA, 8'd0);
    repeat (8) @(negedge clk);
    checkOutput("enDropNoDone", doneCount, doneBefore);
    pushExp(8'd16);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkFirstTick("reEnable");

    // Drop enable exactly on the tick that would end S_HOLD_LO.
    $display("[TB] enable drop coincident with final hold tick");
    for (int k = 2; k <= 15; k++) pushExp(8'(16 * k));
    pushExp(8'd255);
    for (int k = 1; k <= 15; k++) pushExp(8'(255 - 16 * k));
    pushExp(8'd0);
    waitDuty("reach31", mapDuty(8'd31), 400);
    repeat (16 - LAT) @(negedge clk);
    doneBefore = doneCount;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (6) @(negedge clk);
    checkOutput("coincNoDone", doneCount, doneBefore);
    checkOutput("coincDark", dutyA, 8'd0);

    // Asynchronous reset between clock edges.
    $display("[TB] asynchronous reset mid-ramp");
    pushExp(8'd16);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkFirstTick("reEnable2");
    pushExp(8'd32);
    pushExp(8'd48);
    waitDuty("reach48", mapDuty(8'd48), 40);
    pushExp(8'd0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetDuty", dutyA, 8'd0);
    checkOutput("asyncResetDone", doneA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pushExp(8'd16);
    rst_n = 1'b1;
    checkFirstTick("afterReset");

    // Manual levels at the boundaries and the gamma reference points.
    $display("[TB] manual boundary levels");
    for (int i = 0; i < 4; i++) begin
      pushExp(boundLevels[i]);
      applyStimulus(1'b1, 1'b1, boundLevels[i]);
      repeat (LAT) @(negedge clk);
      checkOutput($sformatf("manualLevel%0d", boundLevels[i]), dutyA,
                  mapDuty(boundLevels[i]));
    end
    pushExp(8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (LAT + 2) @(negedge clk);
    checkOutput("queueDrain2", expDuty.size(), 0);
    checkOutput("doneWidthAll", doneWide, 0);

    // Instance B: large step saturates at both ends.
    $display("[TB] large step ramp");
    for (int i = 0; i < 6; i++) expB.push_back(mapDuty(bSeq[i]));
    enB = 1'b1;
    while (expB.size() > 0) begin
      n = 0;
      while (dutyB === lastB && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("rampB", dutyB, expB.pop_front());
      lastB = dutyB;
    end
    n = 0;
    while (doneB !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneB", doneB, 1'b1);
    @(negedge clk);
    checkOutput("doneWidthB", doneB, 1'b0);
    enB = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
